// File: rtl/clk_gate_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// clk_gate_ctrl_pkg
//   Shared definitions for the clock gate controller slice.
//   - state_e      : controller FSM encoding (RUN=0, IDLE_WAIT=1, GATED=2, WAKE=3)
//   - WAKE_CYC_DEF : default number of clock-tree settle cycles spent in WAKE
//   - WAKE_CNT_W   : width of the WAKE settle counter (covers WAKE_CYC 1..15)
// ---------------------------------------------------------------------------
package clk_gate_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      IDLE_WAIT = 2'd1,
      GATED     = 2'd2,
      WAKE      = 2'd3
   } state_e;

   localparam int WAKE_CYC_DEF = 2;
   localparam int WAKE_CNT_W   = 4;

endpackage : clk_gate_ctrl_pkg

// File: rtl/clk_gate_sync.sv
// ---------------------------------------------------------------------------
// clk_gate_sync
//   Two-flop synchronizer bringing an asynchronous level into the clk domain.
//   Ports:
//     clk   - destination clock
//     rst_b - asynchronous active-low reset, clears both flops to 0
//     d     - asynchronous input level
//     q     - synchronized level (two clk edges of latency)
// ---------------------------------------------------------------------------
module clk_gate_sync
   import clk_gate_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst_b,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule : clk_gate_sync

// File: rtl/clk_gate_ctrl.sv
// ---------------------------------------------------------------------------
// clk_gate_ctrl
//   Decides when the downstream clock may be gated. After cfg_idle_thr+1
//   consecutive idle cycles (with automatic gating enabled) gate_en drops;
//   any wake source re-enables the gate and, after WAKE_CYC settle cycles,
//   the FSM is back in RUN. The gate cell itself lives in the parent.
//
//   Parameters:
//     WAKE_CYC - settle cycles between gate re-enable and RUN (1..15)
//     THR_W    - width of cfg_idle_thr
//   Ports:
//     clk          - free-running source clock (also the gate cell CK)
//     rst_b        - asynchronous active-low reset
//     cfg_auto_en  - automatic gating enable
//     cfg_idle_thr - idle cycles to wait (compared before each increment)
//     blk_idle     - downstream block idle indication
//     wake_req     - asynchronous wake request level (always-on domain)
//     scan_mode    - DFT scan mode, forwarded to gate_se only
//     gate_en      - gate cell EN, registered, 0 only while GATED
//     gate_se      - gate cell SE, equals scan_mode
//     wake_ack     - wake acknowledge level
//     gated_sts    - high while the downstream clock is gated
//     fsm_state    - current FSM state, for observation
//
//   Wake handshake: wake_req/wake_ack is a four-phase level handshake. The
//   requester raises wake_req and holds it; wake_ack rises once the clock is
//   running and settled (state RUN) and stays high while the synchronized
//   request is high; it drops one edge after the synchronized request drops.
//   While wake_ack is high the FSM is pinned in RUN.
// ---------------------------------------------------------------------------
module clk_gate_ctrl
   import clk_gate_ctrl_pkg::*;
#(
   parameter int WAKE_CYC = WAKE_CYC_DEF,
   parameter int THR_W    = 8
)(
   input  logic             clk,
   input  logic             rst_b,
   input  logic             cfg_auto_en,
   input  logic [THR_W-1:0] cfg_idle_thr,
   input  logic             blk_idle,
   input  logic             wake_req,
   input  logic             scan_mode,
   output logic             gate_en,
   output logic             gate_se,
   output logic             wake_ack,
   output logic             gated_sts,
   output logic [1:0]       fsm_state
);

   localparam logic [WAKE_CNT_W-1:0] WAKE_LAST = WAKE_CNT_W'(WAKE_CYC - 1);

   state_e                state, state_nxt;
   logic [THR_W-1:0]      idle_cnt, idle_cnt_nxt;
   logic [WAKE_CNT_W-1:0] wake_cnt, wake_cnt_nxt;
   logic                  wake_req_s;
   logic                  idle_abort;
   logic                  gate_wake;

   clk_gate_sync u_wake_sync (
      .clk   (clk),
      .rst_b (rst_b),
      .d     (wake_req),
      .q     (wake_req_s)
   );

   assign idle_abort = !blk_idle || !cfg_auto_en || wake_req_s;
   assign gate_wake  = wake_req_s || !blk_idle || !cfg_auto_en;

   always_comb begin
      state_nxt    = state;
      idle_cnt_nxt = idle_cnt;
      wake_cnt_nxt = wake_cnt;
      case (state)
         RUN: begin
            // wake_ack lags wake_req_s by one edge; gating on it as well
            // keeps the FSM in RUN for the whole acknowledge phase.
            if (cfg_auto_en && blk_idle && !wake_req_s && !wake_ack) begin
               state_nxt    = IDLE_WAIT;
               idle_cnt_nxt = '0;
            end
         end
         IDLE_WAIT: begin
            if (idle_abort) begin
               state_nxt = RUN;
            end else if (idle_cnt == cfg_idle_thr) begin
               state_nxt = GATED;
            end else if (idle_cnt != '1) begin
               // Saturate so a threshold lowered below the count can never
               // be reached by wrap-around.
               idle_cnt_nxt = idle_cnt + THR_W'(1);
            end
         end
         GATED: begin
            if (gate_wake) begin
               state_nxt    = WAKE;
               wake_cnt_nxt = '0;
            end
         end
         WAKE: begin
            // Clock tree settling: inputs are deliberately ignored here.
            if (wake_cnt == WAKE_LAST) begin
               state_nxt = RUN;
            end else begin
               wake_cnt_nxt = wake_cnt + WAKE_CNT_W'(1);
            end
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state    <= RUN;
         idle_cnt <= '0;
         wake_cnt <= '0;
         gate_en  <= 1'b1;
         wake_ack <= 1'b0;
      end else begin
         state    <= state_nxt;
         idle_cnt <= idle_cnt_nxt;
         wake_cnt <= wake_cnt_nxt;
         // Registered from next-state so EN changes on the same edge the
         // FSM enters or leaves GATED.
         gate_en  <= (state_nxt != GATED);
         wake_ack <= (state_nxt == RUN) && wake_req_s;
      end
   end

   assign gated_sts = !gate_en;
   assign gate_se   = scan_mode;
   assign fsm_state = state;

endmodule : clk_gate_ctrl

// File: tb/tb_clk_gate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_gate_ctrl
//   Directed bench for clk_gate_ctrl with default parameters
//   (WAKE_CYC=2, THR_W=8). Inputs change on the falling edge, outputs are
//   sampled on the following falling edge.
// ---------------------------------------------------------------------------
module tb_clk_gate_ctrl;
   import clk_gate_ctrl_pkg::*;

   typedef struct {
      logic       auto_en;
      logic       idle;
      logic [7:0] thr;
      logic       scan;
      logic [1:0] st;
      logic       ge;
   } vec_t;

   logic       clk;
   logic       rst_b;
   logic       cfg_auto_en;
   logic [7:0] cfg_idle_thr;
   logic       blk_idle;
   logic       wake_req;
   logic       scan_mode;
   logic       gate_en;
   logic       gate_se;
   logic       wake_ack;
   logic       gated_sts;
   logic [1:0] fsm_state;

   int total;
   int bad;

   vec_t       vq[$];
   logic [5:0] exp_q[$];

   clk_gate_ctrl dut (
      .clk          (clk),
      .rst_b        (rst_b),
      .cfg_auto_en  (cfg_auto_en),
      .cfg_idle_thr (cfg_idle_thr),
      .blk_idle     (blk_idle),
      .wake_req     (wake_req),
      .scan_mode    (scan_mode),
      .gate_en      (gate_en),
      .gate_se      (gate_se),
      .wake_ack     (wake_ack),
      .gated_sts    (gated_sts),
      .fsm_state    (fsm_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic drive(input logic a, input logic i, input logic [7:0] t, input logic w);
      cfg_auto_en  = a;
      blk_idle     = i;
      cfg_idle_thr = t;
      wake_req     = w;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic add(input logic a, input logic i, input logic [7:0] t,
                      input logic [1:0] st, input logic ge);
      vec_t v;
      v.auto_en = a;
      v.idle    = i;
      v.thr     = t;
      v.scan    = logic'(vq.size() % 2);
      v.st      = st;
      v.ge      = ge;
      vq.push_back(v);
   endtask

   // ---------------- scoreboard ----------------
   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic chk_outs(input string name, input logic [1:0] st,
                           input logic ge, input logic wa);
      chk2({name, "_state"}, fsm_state, st);
      chk1({name, "_gate_en"}, gate_en, ge);
      chk1({name, "_gated_sts"}, gated_sts, !ge);
      chk1({name, "_wake_ack"}, wake_ack, wa);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [5:0] e;
      total = 0;
      bad   = 0;
      rst_b = 1'b0;
      scan_mode = 1'b0;
      drive(1'b1, 1'b1, 8'd3, 1'b0);

      // thr=3 from reset: IDLE_WAIT at edge 1, GATED at edge 5
      repeat (4) add(1'b1, 1'b1, 8'd3, IDLE_WAIT, 1'b1);
      add(1'b1, 1'b1, 8'd3, GATED, 1'b0);
      // blk_idle drop wakes; WAKE ignores inputs for 2 cycles
      add(1'b1, 1'b0, 8'd3, WAKE, 1'b1);
      add(1'b1, 1'b1, 8'd3, WAKE, 1'b1);
      add(1'b1, 1'b1, 8'd3, RUN, 1'b1);
      // re-enter IDLE_WAIT, abort after counter reached 2
      repeat (3) add(1'b1, 1'b1, 8'd3, IDLE_WAIT, 1'b1);
      add(1'b1, 1'b0, 8'd3, RUN, 1'b1);
      add(1'b1, 1'b0, 8'd3, RUN, 1'b1);
      // threshold changed mid IDLE_WAIT: lowered below count, then raised
      repeat (4) add(1'b1, 1'b1, 8'd3, IDLE_WAIT, 1'b1);
      repeat (2) add(1'b1, 1'b1, 8'd1, IDLE_WAIT, 1'b1);
      add(1'b1, 1'b1, 8'd6, IDLE_WAIT, 1'b1);
      add(1'b1, 1'b1, 8'd6, GATED, 1'b0);
      // auto enable dropped while GATED
      add(1'b0, 1'b1, 8'd6, WAKE, 1'b1);
      add(1'b0, 1'b1, 8'd6, WAKE, 1'b1);
      add(1'b0, 1'b1, 8'd6, RUN, 1'b1);
      add(1'b0, 1'b1, 8'd6, RUN, 1'b1);

      // reset state, with inputs that would otherwise start gating
      repeat (3) @(negedge clk);
      chk_outs("reset", RUN, 1'b1, 1'b0);
      chk1("reset_gate_se", gate_se, 1'b0);

      // table-driven run, starting at reset release
      rst_b = 1'b1;
      for (int k = 0; k < vq.size(); k++) begin
         drive(vq[k].auto_en, vq[k].idle, vq[k].thr, 1'b0);
         scan_mode = vq[k].scan;
         exp_q.push_back({vq[k].st, vq[k].ge, !vq[k].ge, 1'b0, vq[k].scan});
         step();
         e = exp_q.pop_front();
         chk2($sformatf("row%0d_state", k), fsm_state, e[5:4]);
         chk1($sformatf("row%0d_gate_en", k), gate_en, e[3]);
         chk1($sformatf("row%0d_gated_sts", k), gated_sts, e[2]);
         chk1($sformatf("row%0d_wake_ack", k), wake_ack, e[1]);
         chk1($sformatf("row%0d_gate_se", k), gate_se, e[0]);
      end

      // thr=0: GATED two edges after reset release; auto_en drop wakes
      scan_mode = 1'b0;
      rst_b = 1'b0;
      #1 chk_outs("thr0_rst", RUN, 1'b1, 1'b0);
      @(negedge clk);
      rst_b = 1'b1;
      drive(1'b1, 1'b1, 8'd0, 1'b0);
      step(); chk_outs("thr0_e1", IDLE_WAIT, 1'b1, 1'b0);
      step(); chk_outs("thr0_e2", GATED, 1'b0, 1'b0);
      scan_mode = 1'b1;
      #1 chk1("scan_gated_se", gate_se, 1'b1);
      chk1("scan_gated_en", gate_en, 1'b0);
      @(negedge clk);
      chk_outs("scan_gated_hold", GATED, 1'b0, 1'b0);
      scan_mode = 1'b0;
      drive(1'b0, 1'b1, 8'd0, 1'b0);
      step(); chk_outs("thr0_e3", WAKE, 1'b1, 1'b0);
      step(); chk_outs("thr0_e4", WAKE, 1'b1, 1'b0);
      step(); chk_outs("thr0_e5", RUN, 1'b1, 1'b0);
      step(); chk_outs("thr0_e6", RUN, 1'b1, 1'b0);

      // wake request from GATED, full handshake
      drive(1'b1, 1'b1, 8'd0, 1'b0);
      step(); chk_outs("wk_pre1", IDLE_WAIT, 1'b1, 1'b0);
      step(); chk_outs("wk_pre2", GATED, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 8'd0, 1'b1);
      step(); chk_outs("wk_e1", GATED, 1'b0, 1'b0);
      step(); chk_outs("wk_e2", GATED, 1'b0, 1'b0);
      step(); chk_outs("wk_e3", WAKE, 1'b1, 1'b0);
      step(); chk_outs("wk_e4", WAKE, 1'b1, 1'b0);
      step(); chk_outs("wk_e5", RUN, 1'b1, 1'b1);
      step(); chk_outs("wk_e6", RUN, 1'b1, 1'b1);
      drive(1'b1, 1'b1, 8'd0, 1'b0);
      step(); chk_outs("wk_e7", RUN, 1'b1, 1'b1);
      step(); chk_outs("wk_e8", RUN, 1'b1, 1'b1);
      step(); chk_outs("wk_e9", RUN, 1'b1, 1'b0);
      step(); chk_outs("wk_e10", IDLE_WAIT, 1'b1, 1'b0);
      step(); chk_outs("wk_e11", GATED, 1'b0, 1'b0);

      // asynchronous reset mid-GATED
      rst_b = 1'b0;
      #1 chk_outs("rst_gated", RUN, 1'b1, 1'b0);
      @(negedge clk);
      rst_b = 1'b1;
      step(); chk_outs("rst_r1", IDLE_WAIT, 1'b1, 1'b0);
      step(); chk_outs("rst_r2", GATED, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 8'd0, 1'b0);
      step(); chk_outs("rst_r3", WAKE, 1'b1, 1'b0);

      // asynchronous reset mid-WAKE
      #2 rst_b = 1'b0;
      #1 chk_outs("rst_wake", RUN, 1'b1, 1'b0);
      @(negedge clk);
      rst_b = 1'b1;

      // wake_ack raised in RUN, then cleared asynchronously by reset
      drive(1'b0, 1'b1, 8'd0, 1'b1);
      step(); chk_outs("ack_e1", RUN, 1'b1, 1'b0);
      step(); chk_outs("ack_e2", RUN, 1'b1, 1'b0);
      step(); chk_outs("ack_e3", RUN, 1'b1, 1'b1);
      #2 rst_b = 1'b0;
      #1 chk_outs("rst_ack", RUN, 1'b1, 1'b0);
      step(); chk_outs("rst_ack_hold", RUN, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_clk_gate_ctrl
